// File: rtl/player_bullet.sv
// Player projectile: spawns one bullet centred on the ship on a fire request and moves it up once per frame.
// The bullet retires on a hit or at the top of the screen, then a frame-counted cooldown re-arms firing.
module player_bullet #(
    parameter int BULLET_W  = 2,
    parameter int BULLET_H  = 8,
    parameter int SPEED     = 8,
    parameter int SHIP_Y    = 440,
    parameter int SHIP_BASE = 16,
    parameter int COOLDOWN  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       fire,
    input  logic [9:0] ship_x_pos,
    input  logic [3:0] scale,
    input  logic       hit,
    output logic       bullet_on,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic       shot_fired
);
    // state       | meaning
    // ST_READY    | armed, waiting for a fire press and then a frame tick
    // ST_FLYING   | bullet in flight, moving up SPEED pixels per frame
    // ST_COOLDOWN | bullet retired, counting frames before re-arming
    typedef enum logic [1:0] {ST_READY, ST_FLYING, ST_COOLDOWN} state_t;

    localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    state_t             state, state_nxt;
    logic               v_sync_d, fire_d;
    logic               fire_pending, pending_nxt, shot_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [9:0]         bx_nxt, by_nxt;
    logic               tick, fire_rise;
    logic [3:0]         scale_eff;
    logic [10:0]        spawn_raw;
    logic [9:0]         spawn_x;
    logic [10:0]        px11, py11, bx11, by11;

    assign tick      = v_sync & ~v_sync_d;
    assign fire_rise = fire & ~fire_d;
    assign scale_eff = (scale == 4'd0) ? 4'd1 : scale;

    // Computed in 11 bits so a ship near the right edge cannot wrap before the clamp.
    assign spawn_raw = {1'b0, ship_x_pos}
                     + ((11'(SHIP_BASE) * {7'd0, scale_eff}) >> 1)
                     - 11'(BULLET_W / 2);
    assign spawn_x   = (spawn_raw > 11'(640 - BULLET_W)) ? 10'(640 - BULLET_W) : spawn_raw[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_READY;
            v_sync_d     <= 1'b1;
            fire_d       <= 1'b1;
            fire_pending <= 1'b0;
            cnt          <= '0;
            bullet_x     <= '0;
            bullet_y     <= '0;
            shot_fired   <= 1'b0;
        end else begin
            state        <= state_nxt;
            v_sync_d     <= v_sync;
            fire_d       <= fire;
            fire_pending <= pending_nxt;
            cnt          <= cnt_nxt;
            bullet_x     <= bx_nxt;
            bullet_y     <= by_nxt;
            shot_fired   <= shot_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = fire_pending;
        cnt_nxt     = cnt;
        bx_nxt      = bullet_x;
        by_nxt      = bullet_y;
        shot_nxt    = 1'b0;
        case (state)
            ST_READY: begin
                if (tick && fire_pending) begin
                    state_nxt   = ST_FLYING;
                    bx_nxt      = spawn_x;
                    by_nxt      = 10'(SHIP_Y - BULLET_H);
                    pending_nxt = 1'b0;
                    shot_nxt    = 1'b1;
                end else if (fire_rise) begin
                    pending_nxt = 1'b1;
                end
            end
            ST_FLYING: begin
                if (hit) begin
                    state_nxt = ST_COOLDOWN;
                    cnt_nxt   = CNT_W'(COOLDOWN);
                end else if (tick) begin
                    if (bullet_y < 10'(SPEED)) begin
                        state_nxt = ST_COOLDOWN;
                        cnt_nxt   = CNT_W'(COOLDOWN);
                    end else begin
                        by_nxt = bullet_y - 10'(SPEED);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cnt == '0) state_nxt = ST_READY;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_READY;
        endcase
    end

    assign bullet_active = (state == ST_FLYING);

    assign px11 = {1'b0, pix_x};
    assign py11 = {1'b0, pix_y};
    assign bx11 = {1'b0, bullet_x};
    assign by11 = {1'b0, bullet_y};

    assign bullet_on = bullet_active
                     && (px11 >= bx11) && (px11 < bx11 + 11'(BULLET_W))
                     && (py11 >= by11) && (py11 < by11 + 11'(BULLET_H));
endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: directed scenarios then random frames, all checked against a frame-level model.
module tb_player_bullet;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_sync, fire, hit;
    logic [9:0] pix_x, pix_y, ship_x_pos;
    logic [3:0] scale;
    logic       bullet_on, bullet_active, shot_fired;
    logic [9:0] bullet_x, bullet_y;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integers describing the game object, not the RTL's registers.
    int  m_vs_prev, m_fire_prev;
    bit  m_flying, m_cooling, m_armed_press, m_shot;
    int  m_frames_left, m_x, m_y;

    player_bullet dut (
        .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .pix_x(pix_x), .pix_y(pix_y),
        .fire(fire), .ship_x_pos(ship_x_pos), .scale(scale), .hit(hit),
        .bullet_on(bullet_on), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active), .shot_fired(shot_fired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vs_prev = 1; m_fire_prev = 1;
        m_flying = 0; m_cooling = 0; m_armed_press = 0; m_shot = 0;
        m_frames_left = 0; m_x = 0; m_y = 0;
    endtask

    function automatic int spawn_pos();
        int s, p;
        s = (scale == 0) ? 1 : int'(scale);
        p = int'(ship_x_pos) + (16 * s) / 2 - 1;
        return (p > 638) ? 638 : p;
    endfunction

    task automatic model_clock();
        bit t, r;
        t = v_sync && (m_vs_prev == 0);
        r = fire && (m_fire_prev == 0);
        m_vs_prev = int'(v_sync);
        m_fire_prev = int'(fire);
        m_shot = 0;
        if (m_flying) begin
            if (hit || (t && m_y < 8)) begin
                m_flying = 0; m_cooling = 1; m_frames_left = 9;
            end else if (t) begin
                m_y = m_y - 8;
            end
        end else if (m_cooling) begin
            if (t) begin
                m_frames_left--;
                if (m_frames_left == 0) m_cooling = 0;
            end
        end else if (t && m_armed_press) begin
            m_flying = 1; m_armed_press = 0; m_shot = 1;
            m_x = spawn_pos(); m_y = 432;
        end else if (r) begin
            m_armed_press = 1;
        end
    endtask

    task automatic check_all();
        bit on;
        on = m_flying && int'(pix_x) >= m_x && int'(pix_x) < m_x + 2
                      && int'(pix_y) >= m_y && int'(pix_y) < m_y + 8;
        chk("active", 32'(bullet_active), 32'(m_flying));
        chk("x", 32'(bullet_x), 32'(m_x));
        chk("y", 32'(bullet_y), 32'(m_y));
        chk("shot", 32'(shot_fired), 32'(m_shot));
        chk("on", 32'(bullet_on), 32'(on));
    endtask

    task automatic step(input logic vs, input logic f, input logic h,
                        input logic [9:0] px, input logic [9:0] py);
        v_sync = vs; fire = f; hit = h; pix_x = px; pix_y = py;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    // One frame: three clocks of low v_sync then the rising edge (tick on the last clock).
    task automatic frame(input logic f);
        for (int i = 0; i < 3; i++) step(1'b0, f, 1'b0, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
        step(1'b1, f, 1'b0, 10'(m_x + 1), 10'(m_y + 3));
    endtask

    task automatic retire_and_cool();
        step(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        for (int i = 0; i < 9; i++) frame(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; v_sync = 1'b1; fire = 1'b1; hit = 1'b0;
        pix_x = '0; pix_y = '0; ship_x_pos = 10'd312; scale = 4'd1;
        model_reset();
        #2;
        chk("rst_active", 32'(bullet_active), 32'd0);
        chk("rst_y", 32'(bullet_y), 32'd0);
        #10 rst_n = 1'b1;

        // Held fire and high v_sync across reset produce nothing
        for (int i = 0; i < 3; i++) begin
            frame(1'b1);
            chk("held_fire_no_spawn", 32'(bullet_active), 32'd0);
        end

        // Centred spawn at scale 1
        frame(1'b0);
        frame(1'b1);
        chk("spawn_shot", 32'(shot_fired), 32'd1);
        chk("spawn_x", 32'(bullet_x), 32'd319);
        chk("spawn_y", 32'(bullet_y), 32'd432);
        step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        chk("shot_one_clk", 32'(shot_fired), 32'd0);

        // Climb to the top row and retire off-screen
        for (int k = 1; k <= 54; k++) frame(1'b0);
        chk("top_y", 32'(bullet_y), 32'd0);
        chk("top_active", 32'(bullet_active), 32'd1);
        frame(1'b0);
        chk("offscreen_retire", 32'(bullet_active), 32'd0);
        chk("offscreen_y_hold", 32'(bullet_y), 32'd0);

        // A press after eight cooldown ticks is still ignored; holding it gives no shot
        for (int k = 1; k <= 8; k++) frame(1'b0);
        frame(1'b1);
        frame(1'b1);
        chk("no_queued_shot", 32'(bullet_active), 32'd0);
        frame(1'b0);
        frame(1'b1);
        chk("refire_shot", 32'(shot_fired), 32'd1);

        // Hit coincident with a tick, with fire pressed during flight
        frame(1'b1);
        chk("fly_y", 32'(bullet_y), 32'd424);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        step(1'b1, 1'b0, 1'b1, 10'd320, 10'd428);
        chk("hit_active", 32'(bullet_active), 32'd0);
        chk("hit_y_hold", 32'(bullet_y), 32'd424);
        chk("hit_on", 32'(bullet_on), 32'd0);
        frame(1'b0);
        frame(1'b1);
        for (int k = 3; k <= 9; k++) frame(1'b0);
        chk("cool_no_shot", 32'(bullet_active), 32'd0);
        frame(1'b1);
        chk("ready_after_9", 32'(shot_fired), 32'd1);

        // Wide ship: spawn at 631 and pixel window check
        retire_and_cool();
        scale = 4'd4; ship_x_pos = 10'd600;
        frame(1'b1);
        chk("wide_x", 32'(bullet_x), 32'd631);
        for (int px = 629; px <= 634; px++)
            for (int py = 430; py <= 441; py++) begin
                step(1'b0, 1'b0, 1'b0, 10'(px), 10'(py));
                chk("scan_on", 32'(bullet_on), 32'(px >= 631 && px <= 632 && py >= 432 && py <= 439));
            end

        // Clamp at the right edge
        retire_and_cool();
        scale = 4'd8; ship_x_pos = 10'd630;
        frame(1'b1);
        chk("clamp_x", 32'(bullet_x), 32'd638);

        // Reset in flight kills the bullet asynchronously
        rst_n = 1'b0;
        #1;
        chk("async_kill", 32'(bullet_active), 32'd0);
        chk("async_x", 32'(bullet_x), 32'd0);
        model_reset();
        rst_n = 1'b1;

        // Random play
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) begin
                ship_x_pos = 10'($urandom_range(0, 639));
                scale = 4'($urandom_range(0, 15));
            end
            step($urandom_range(0, 2) == 0,
                 ($urandom_range(0, 5) == 0) ? ~fire : fire,
                 $urandom_range(0, 29) == 0,
                 10'(m_x + int'($urandom_range(0, 5)) - 2),
                 10'(m_y + int'($urandom_range(0, 11)) - 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
